// File: rtl/command_codec_pkg.sv
// Shared types, constants and the checksum helper for the command packet codec.
package command_codec_pkg;

    typedef enum logic [0:0] {RX_IDLE, RX_COLLECT} rx_state_t;
    typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_t;

    localparam int unsigned BYTES_PER_MSG = 6;
    localparam int unsigned SYNC_WIDTH    = 3;
    localparam logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 3'b101;
    localparam int unsigned HDR_SYNC_LSB  = 5;
    localparam int unsigned HDR_CMD_LSB   = 0;

    // Checksum byte is the XOR of the header and the four payload bytes.
    function automatic logic [7:0] xor_checksum(input logic [8*(BYTES_PER_MSG-1)-1:0] bytes);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < int'(BYTES_PER_MSG) - 1; i++) begin
            acc ^= bytes[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/command_packet_tx.sv
// TX serializer: shifts a latched 48-bit message out MSB byte first under valid/ready.
module command_packet_tx
    import command_codec_pkg::*;
#(
    parameter int unsigned MSG_LENGTH = 48
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_send_data,
    input  logic [MSG_LENGTH-1:0] i_tx_data,
    input  logic                  i_tx_byte_ready,
    output logic                  o_data_sent,
    output logic                  o_tx_byte_valid,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_busy
);

    tx_state_t             r_state;
    logic [MSG_LENGTH-1:0] r_shreg;
    logic [2:0]            r_idx;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_sent;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= TX_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_sent  <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            unique case (r_state)
                TX_IDLE: begin
                    // The data_sent cycle counts as the mandatory idle gap.
                    if (i_send_data && !r_sent) begin
                        r_shreg <= i_tx_data;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (r_valid && i_tx_byte_ready) begin
                        if (r_idx == 3'(BYTES_PER_MSG - 1)) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_sent  <= 1'b1;
                            r_state <= TX_IDLE;
                        end else begin
                            r_shreg <= {r_shreg[MSG_LENGTH-9:0], 8'h00};
                            r_idx   <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign o_data_sent     = r_sent;
    assign o_tx_byte_valid = r_valid;
    assign o_tx_byte       = r_shreg[MSG_LENGTH-1 -: 8];
    assign o_tx_busy       = r_busy;

endmodule

// File: rtl/command_packet_codec.sv
// Byte-level packet framing: RX assembles and checks 6-byte packets, TX serializes messages.
module command_packet_codec
    import command_codec_pkg::*;
#(
    parameter int unsigned MSG_LENGTH     = 48,
    parameter int unsigned DATA_LENGTH    = 32,
    parameter int unsigned COMMAND_WIDTH  = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_rx_byte_valid,
    input  logic [7:0]               i_rx_byte,
    output logic                     o_packet_received,
    output logic [COMMAND_WIDTH-1:0] o_command,
    output logic [DATA_LENGTH-1:0]   o_rx_data,
    output logic                     o_packet_error,
    input  logic                     i_send_data,
    input  logic [MSG_LENGTH-1:0]    i_tx_data,
    output logic                     o_data_sent,
    output logic                     o_tx_byte_valid,
    output logic [7:0]               o_tx_byte,
    input  logic                     i_tx_byte_ready,
    output logic                     o_tx_busy
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    rx_state_t                r_rx_state;
    logic [7:0]               r_header;
    logic [DATA_LENGTH-1:0]   r_payload;
    logic [2:0]               r_idx;
    logic [GAP_W-1:0]         r_gap;
    logic                     r_packet_received;
    logic                     r_packet_error;
    logic [COMMAND_WIDTH-1:0] r_command;
    logic [DATA_LENGTH-1:0]   r_rx_data;
    logic                     w_sync_ok;

    assign w_sync_ok = (i_rx_byte[HDR_SYNC_LSB +: SYNC_WIDTH] == SYNC_PATTERN);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rx_state        <= RX_IDLE;
            r_header          <= '0;
            r_payload         <= '0;
            r_idx             <= '0;
            r_gap             <= '0;
            r_packet_received <= 1'b0;
            r_packet_error    <= 1'b0;
            r_command         <= '0;
            r_rx_data         <= '0;
        end else begin
            r_packet_received <= 1'b0;
            r_packet_error    <= 1'b0;
            unique case (r_rx_state)
                RX_IDLE: begin
                    r_gap <= '0;
                    if (i_rx_byte_valid && w_sync_ok) begin
                        r_header   <= i_rx_byte;
                        r_idx      <= 3'd1;
                        r_rx_state <= RX_COLLECT;
                    end
                end
                RX_COLLECT: begin
                    if (i_rx_byte_valid) begin
                        r_gap <= '0;
                        if (r_idx == 3'(BYTES_PER_MSG - 1)) begin
                            r_idx      <= '0;
                            r_rx_state <= RX_IDLE;
                            if (i_rx_byte == xor_checksum({r_header, r_payload})) begin
                                r_packet_received <= 1'b1;
                                r_command <= r_header[HDR_CMD_LSB +: COMMAND_WIDTH];
                                r_rx_data <= r_payload;
                            end else begin
                                r_packet_error <= 1'b1;
                            end
                        end else begin
                            r_payload <= {r_payload[DATA_LENGTH-9:0], i_rx_byte};
                            r_idx     <= r_idx + 3'd1;
                        end
                    end else if (r_gap == GAP_LAST) begin
                        // This idle cycle brings the gap to TIMEOUT_CYCLES.
                        r_gap          <= '0;
                        r_idx          <= '0;
                        r_packet_error <= 1'b1;
                        r_rx_state     <= RX_IDLE;
                    end else if (r_gap != GAP_MAX) begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_packet_received = r_packet_received;
    assign o_packet_error    = r_packet_error;
    assign o_command         = r_command;
    assign o_rx_data         = r_rx_data;

    command_packet_tx #(
        .MSG_LENGTH(MSG_LENGTH)
    ) u_tx (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_send_data    (i_send_data),
        .i_tx_data      (i_tx_data),
        .i_tx_byte_ready(i_tx_byte_ready),
        .o_data_sent    (o_data_sent),
        .o_tx_byte_valid(o_tx_byte_valid),
        .o_tx_byte      (o_tx_byte),
        .o_tx_busy      (o_tx_busy)
    );

endmodule

// File: tb/tb_command_packet_codec.sv
// Directed bench for command_packet_codec: RX framing, checksum, timeout, TX handshake, reset.
module tb_command_packet_codec;

    logic        clk;
    logic        reset_n;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        packet_received;
    logic [4:0]  command;
    logic [31:0] rx_data;
    logic        packet_error;
    logic        send_data;
    logic [47:0] tx_data;
    logic        data_sent;
    logic        tx_byte_valid;
    logic [7:0]  tx_byte;
    logic        tx_byte_ready;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    command_packet_codec u_dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_rx_byte_valid  (rx_byte_valid),
        .i_rx_byte        (rx_byte),
        .o_packet_received(packet_received),
        .o_command        (command),
        .o_rx_data        (rx_data),
        .o_packet_error   (packet_error),
        .i_send_data      (send_data),
        .i_tx_data        (tx_data),
        .o_data_sent      (data_sent),
        .o_tx_byte_valid  (tx_byte_valid),
        .o_tx_byte        (tx_byte),
        .i_tx_byte_ready  (tx_byte_ready),
        .o_tx_busy        (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_byte_valid = 1'b1;
        rx_byte       = b;
        tick();
        rx_byte_valid = 1'b0;
    endtask

    task automatic rx_packet(input logic [47:0] p);
        for (int i = 0; i < 6; i++) begin
            rx_send(p[47-8*i -: 8]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pr"}, 64'(packet_received), 64'd0);
        check_eq({tag, "_err"}, 64'(packet_error), 64'd0);
        check_eq({tag, "_cmd"}, 64'(command), 64'd0);
        check_eq({tag, "_data"}, 64'(rx_data), 64'd0);
        check_eq({tag, "_sent"}, 64'(data_sent), 64'd0);
        check_eq({tag, "_txv"}, 64'(tx_byte_valid), 64'd0);
        check_eq({tag, "_txb"}, 64'(tx_byte), 64'd0);
        check_eq({tag, "_busy"}, 64'(tx_busy), 64'd0);
    endtask

    localparam logic [47:0] PKT_A   = 48'hA3_12345678_AB;  // cmd 03
    localparam logic [47:0] PKT_B   = 48'hA5_11223344_E1;  // cmd 05
    localparam logic [47:0] PKT_BAD = 48'hBF_DEADBEEF_9C;  // correct checksum is 9D

    initial begin
        logic [47:0] exp_msg;
        reset_n       = 1'b0;
        rx_byte_valid = 1'b0;
        rx_byte       = 8'h00;
        send_data     = 1'b0;
        tx_data       = '0;
        tx_byte_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Clean packet.
        rx_packet(PKT_A);
        check_eq("a_pr", 64'(packet_received), 64'd1);
        check_eq("a_err", 64'(packet_error), 64'd0);
        check_eq("a_cmd", 64'(command), 64'h03);
        check_eq("a_data", 64'(rx_data), 64'h12345678);
        tick();
        check_eq("a_pr_pulse", 64'(packet_received), 64'd0);

        // Bad checksum, then a good packet starting the very next cycle.
        rx_packet(PKT_BAD);
        check_eq("bad_err", 64'(packet_error), 64'd1);
        check_eq("bad_pr", 64'(packet_received), 64'd0);
        check_eq("bad_cmd_hold", 64'(command), 64'h03);
        check_eq("bad_data_hold", 64'(rx_data), 64'h12345678);
        rx_packet(PKT_B);
        check_eq("b2b_pr", 64'(packet_received), 64'd1);
        check_eq("b2b_err", 64'(packet_error), 64'd0);
        check_eq("b2b_cmd", 64'(command), 64'h05);
        check_eq("b2b_data", 64'(rx_data), 64'h11223344);
        tick();

        // Timeout: error exactly on the 1000th idle cycle.
        rx_send(8'hA3);
        rx_send(8'h12);
        repeat (999) tick();
        check_eq("to_999_err", 64'(packet_error), 64'd0);
        tick();
        check_eq("to_1000_err", 64'(packet_error), 64'd1);
        tick();
        check_eq("to_pulse", 64'(packet_error), 64'd0);
        rx_packet(PKT_A);
        check_eq("to_after_pr", 64'(packet_received), 64'd1);
        check_eq("to_after_cmd", 64'(command), 64'h03);

        // A 999-cycle gap is still within budget.
        rx_send(8'hA5);
        rx_send(8'h11);
        repeat (999) tick();
        check_eq("gap999_err", 64'(packet_error), 64'd0);
        rx_send(8'h22);
        rx_send(8'h33);
        rx_send(8'h44);
        rx_send(8'hE1);
        check_eq("gap999_pr", 64'(packet_received), 64'd1);
        check_eq("gap999_data", 64'(rx_data), 64'h11223344);
        tick();

        // Bad-sync byte is dropped silently.
        rx_send(8'h43);
        check_eq("sync_err", 64'(packet_error), 64'd0);
        rx_packet(PKT_A);
        check_eq("sync_pr", 64'(packet_received), 64'd1);
        check_eq("sync_cmd", 64'(command), 64'h03);
        check_eq("sync_err2", 64'(packet_error), 64'd0);
        tick();

        // TX with ready toggling; extra send_data mid-transfer must be ignored.
        exp_msg   = 48'hA3_12345678_AB;
        tx_data   = exp_msg;
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
        tx_data   = '0;
        check_eq("tx_busy", 64'(tx_busy), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tx_byte_ready = 1'b0;
            check_eq($sformatf("tx_v%0d", i), 64'(tx_byte_valid), 64'd1);
            check_eq($sformatf("tx_b%0d", i), 64'(tx_byte), 64'(exp_msg[47-8*i -: 8]));
            if (i == 2) begin
                send_data = 1'b1;
                tx_data   = 48'hFFFF_FFFF_FFFF;
            end
            tick();
            send_data = 1'b0;
            check_eq($sformatf("tx_hold%0d", i), 64'(tx_byte), 64'(exp_msg[47-8*i -: 8]));
            check_eq($sformatf("tx_nosent%0d", i), 64'(data_sent), 64'd0);
            tx_byte_ready = 1'b1;
            tick();
        end
        tx_byte_ready = 1'b0;
        check_eq("tx_sent", 64'(data_sent), 64'd1);
        check_eq("tx_v_end", 64'(tx_byte_valid), 64'd0);
        check_eq("tx_busy_end", 64'(tx_busy), 64'd0);
        tick();
        check_eq("tx_sent_pulse", 64'(data_sent), 64'd0);
        check_eq("tx_idle_v", 64'(tx_byte_valid), 64'd0);

        // Reset after 3rd TX byte and 2nd RX byte.
        tx_data   = 48'h112233445566;
        send_data = 1'b1;
        tick();
        send_data     = 1'b0;
        tx_byte_ready = 1'b1;
        rx_byte_valid = 1'b1;
        rx_byte       = 8'hA5;
        tick();
        rx_byte = 8'h11;
        tick();
        rx_byte_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        check_all_zero("mid_rst");
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("rst_nosent%0d", i), 64'(data_sent), 64'd0);
        end
        tx_byte_ready = 1'b0;
        check_eq("rst_txv", 64'(tx_byte_valid), 64'd0);
        rx_send(8'h22);
        rx_send(8'h33);
        rx_send(8'h44);
        rx_send(8'hE1);
        check_eq("rst_tail_pr", 64'(packet_received), 64'd0);
        check_eq("rst_tail_err", 64'(packet_error), 64'd0);
        rx_packet(PKT_B);
        check_eq("rst_fresh_pr", 64'(packet_received), 64'd1);
        check_eq("rst_fresh_cmd", 64'(command), 64'h05);
        check_eq("rst_fresh_data", 64'(rx_data), 64'h11223344);

        // Fresh TX after reset with ready held high.
        exp_msg   = PKT_B;
        tx_data   = exp_msg;
        send_data = 1'b1;
        tick();
        send_data     = 1'b0;
        tx_byte_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("tx2_b%0d", i), 64'(tx_byte), 64'(exp_msg[47-8*i -: 8]));
            tick();
        end
        tx_byte_ready = 1'b0;
        check_eq("tx2_sent", 64'(data_sent), 64'd1);
        check_eq("tx2_busy", 64'(tx_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/command_packet_codec.md
Name: command_packet_codec

Overview:
Byte-level framing stage between the serial link (UART/SPI byte engine) and the command manager. The RX path assembles 6-byte packets, checks sync and checksum, and presents command/rx_data with a packet_received pulse. The TX path serializes the 48-bit tx_data message from the command manager onto a byte stream and returns data_sent. RX and TX are fully independent.

Parameters:
MSG_LENGTH, 48, message width in bits; fixed at 6 bytes
DATA_LENGTH, 32, payload width (bytes 1-4)
COMMAND_WIDTH, 5, command field width (header bits [4:0])
SYNC_PATTERN, 3'b101, required header bits [7:5]
TIMEOUT_CYCLES, 1000, maximum clock cycles allowed between RX bytes within one packet

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  synchronous, active-low reset
rx_byte_valid  in  1  one-cycle strobe: rx_byte is valid
rx_byte  in  8  received byte
packet_received  out  1  one-cycle pulse: valid packet decoded
command  out  COMMAND_WIDTH  command of last valid packet
rx_data  out  DATA_LENGTH  payload of last valid packet
packet_error  out  1  one-cycle pulse: checksum mismatch or timeout
send_data  in  1  request to transmit tx_data
tx_data  in  MSG_LENGTH  message to send, byte 0 = bits [47:40]
data_sent  out  1  one-cycle pulse: all 6 bytes accepted by the link
tx_byte_valid  out  1  tx_byte is valid
tx_byte  out  8  byte to transmit
tx_byte_ready  in  1  link accepts tx_byte this cycle
tx_busy  out  1  TX transfer in progress

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, both FSMs idle, counters cleared. A reset mid-packet drops the partial RX packet and the TX transfer, with no data_sent.
- Packet format: B0 header = {SYNC_PATTERN, command}; B1..B4 payload, MSB first; B5 = XOR of B0..B4.
- RX FSM, states RX_IDLE and RX_COLLECT:
  - RX_IDLE: byte with [7:5]==SYNC_PATTERN -> store header, init running XOR, idx=1, go to RX_COLLECT. Bytes with a bad sync are silently dropped; no error.
  - RX_COLLECT: each valid byte resets the gap counter. Bytes 1-4 shift into the payload register and XOR into the checksum. On byte 5, go to RX_IDLE and compare it to the running XOR on the same edge.
    - Match: next cycle, packet_received=1 for 1 cycle; command and rx_data update on that same cycle and hold until the next valid packet.
    - Mismatch: packet_error pulses for 1 cycle; command and rx_data are unchanged.
  - Latency: packet_received asserts 1 cycle after the clock edge that samples byte 5.
  - Timeout: the gap counter increments each cycle in RX_COLLECT without rx_byte_valid. When it reaches TIMEOUT_CYCLES: packet_error pulses, go to RX_IDLE, partial packet discarded.
  - A byte arriving on the cycle after byte 5 is treated as a new header; no byte is lost.
- TX FSM, states TX_IDLE and TX_SEND:
  - TX_IDLE: send_data=1 -> latch tx_data into a 48-bit shift register, idx=0, tx_busy=1, go to TX_SEND.
  - TX_SEND: tx_byte_valid=1 and tx_byte = shreg[47:40].
    - A byte transfers on any cycle with valid && ready. The next byte is presented on the following cycle (shift left by 8, idx++).
    - Once valid is high, it stays high and tx_byte stays stable until ready.
    - After byte 5 transfers: data_sent pulses the next cycle, tx_byte_valid=0, tx_busy=0, go to TX_IDLE.
  - send_data while tx_busy=1 is ignored; tx_data is sampled only at acceptance.
  - Minimum gap: 1 idle cycle between data_sent and the next accepted send_data.
- Widths: idx is 3 bits. Gap counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.

Decomposition:
- Shared package command_codec_pkg holds:
  - rx_state_t and tx_state_t enums
  - BYTES_PER_MSG=6, SYNC_PATTERN
  - header field offsets
  - xor_checksum function
- Natural split: sub-module command_packet_tx for the TX serializer. The RX path stays in the top module.

Test Plan:
- RX bytes A3,12,34,56,78,AB, one per cycle -> packet_received pulse 1 cycle after AB; command=5'h03, rx_data=32'h12345678; packet_error=0.
- Same packet with last byte AA -> packet_error pulse; command and rx_data keep their previous values; no packet_received.
- Bytes A3,12 then 1000 idle cycles -> packet_error pulse exactly at the 1000th idle cycle. Then A3,12,34,56,78,AB -> a clean packet is received.
- Bad-sync byte 43 then the valid packet A3..AB -> 43 is ignored; the packet is received with no error.
- send_data with tx_data=48'hA312345678AB, tx_byte_ready toggling 1/0 -> bytes A3,12,34,56,78,AB in order, each held stable while ready=0. data_sent 1 cycle after the AB transfer; a second send_data mid-transfer is ignored.
- Assert reset_n=0 after the 3rd TX byte and after the 2nd RX byte -> all outputs 0, no data_sent. A fresh packet after reset decodes correctly.
